axis_frame_reader: RTL and testbench

- Consumer-side companion to the frame FIFO: sits on the FIFO's master AXI-stream output and reads frames out one at a time.
- Forwards each beat through a one-stage output register.
- Counts beats per frame and enforces an optional maximum frame length by truncating and discarding the remainder.
- Emits one per-frame status word (length, bad, truncated) on a separate valid/ready status channel before accepting the next frame.

---
 rtl/axis_frame_reader.sv | 174 +++++++++++++++++
 tb/tb_axis_frame_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_reader.sv
// AXI-stream frame reader: forwards one frame at a time through a single
// output register, counts beats, truncates frames longer than MAX_LEN and
// reports a per-frame status word on an independent valid/ready channel.
module axis_frame_reader #(
  parameter int unsigned           DATA_WIDTH           = 8,
  parameter int unsigned           USER_WIDTH           = 1,
  parameter int unsigned           LEN_WIDTH            = 16,
  parameter int unsigned           MAX_LEN              = 0,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [LEN_WIDTH-1:0]  m_status_len,
  output logic                  m_status_bad,
  output logic                  m_status_trunc,
  output logic                  m_status_valid,
  input  logic                  m_status_ready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FRAME  = 2'd1,
    ST_DROP   = 2'd2,
    ST_STATUS = 2'd3
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] LEN_SAT  = {LEN_WIDTH{1'b1}};
  localparam logic                 TRUNC_EN = (MAX_LEN != 32'd0);

  state_t               state_r;
  state_t               state_s;
  logic [LEN_WIDTH-1:0] cnt_r;
  logic [LEN_WIDTH-1:0] cnt_inc_s;
  logic                 trunc_r;
  logic                 ready_s;
  logic                 accept_s;
  logic                 fwd_s;
  logic                 trunc_hit_s;
  logic                 bad_match_s;
  logic                 st_hs_s;

  assign s_axis_tready = ready_s;

  // Input ready per state, beat qualifiers and the saturating next count.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_FRAME: ready_s = !m_axis_tvalid || m_axis_tready;
      ST_DROP:           ready_s = 1'b1;
      ST_STATUS:         ready_s = 1'b0;
      default:           ready_s = 1'b0;
    endcase

    accept_s = s_axis_tvalid && ready_s;
    fwd_s    = accept_s && ((state_r == ST_IDLE) || (state_r == ST_FRAME));
    st_hs_s  = m_status_valid && m_status_ready;

    if (cnt_r == LEN_SAT) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + LEN_ONE;
    end

    // Exact fit (limit reached on the last beat) is not a truncation.
    trunc_hit_s = fwd_s && TRUNC_EN && !s_axis_tlast
                  && (32'(cnt_inc_s) == MAX_LEN);

    bad_match_s = |(USER_BAD_FRAME_MASK & ~(s_axis_tuser ^ USER_BAD_FRAME_VALUE));
  end

  // Next-state selection for the frame sequencing FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_FRAME: begin
        if (accept_s && s_axis_tlast) begin
          state_s = ST_STATUS;
        end else if (trunc_hit_s) begin
          state_s = ST_DROP;
        end else if (accept_s) begin
          state_s = ST_FRAME;
        end else begin
          state_s = state_r;
        end
      end
      ST_DROP: begin
        if (accept_s && s_axis_tlast) begin
          state_s = ST_STATUS;
        end else begin
          state_s = ST_DROP;
        end
      end
      ST_STATUS: begin
        if (st_hs_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STATUS;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Beat counter and truncation flag, cleared once the status is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= LEN_ZERO;
      trunc_r <= 1'b0;
    end else if (accept_s) begin
      cnt_r   <= cnt_inc_s;
      trunc_r <= trunc_r | trunc_hit_s;
    end else if (st_hs_s) begin
      cnt_r   <= LEN_ZERO;
      trunc_r <= 1'b0;
    end
  end

  // One-stage output register; truncation forces tlast and the bad marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= {DATA_WIDTH{1'b0}};
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= {USER_WIDTH{1'b0}};
    end else if (fwd_s) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tlast  <= s_axis_tlast | trunc_hit_s;
      m_axis_tuser  <= trunc_hit_s ? USER_BAD_FRAME_VALUE : s_axis_tuser;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Status word: captured on the accepted last beat, held until handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_status_valid <= 1'b0;
      m_status_len   <= LEN_ZERO;
      m_status_bad   <= 1'b0;
      m_status_trunc <= 1'b0;
    end else if (accept_s && s_axis_tlast) begin
      m_status_valid <= 1'b1;
      m_status_len   <= cnt_inc_s;
      m_status_bad   <= bad_match_s | trunc_r;
      m_status_trunc <= trunc_r;
    end else if (st_hs_s) begin
      m_status_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_frame_reader.sv
// Self-checking bench for axis_frame_reader: three instances (no limit,
// MAX_LEN=3, 3-bit length counter) share one stimulus bus selected by sel.
module tb_axis_frame_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0] sel;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tlast, s_tuser, m_tready, st_ready;

  logic       v0, v1, v2, r0, r1, r2, mv0, mv1, mv2, ml0, ml1, ml2, mu0, mu1, mu2;
  logic [7:0] md0, md1, md2;
  logic       sb0, sb1, sb2, st0, st1, st2, sv0, sv1, sv2;
  logic [15:0] sl0, sl1;
  logic [2:0]  sl2;

  assign v0 = s_tvalid && (sel == 2'd0);
  assign v1 = s_tvalid && (sel == 2'd1);
  assign v2 = s_tvalid && (sel == 2'd2);

  axis_frame_reader #(.MAX_LEN(0)) u0 (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(v0), .s_axis_tready(r0),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .m_axis_tdata(md0), .m_axis_tvalid(mv0),
    .m_axis_tready(m_tready), .m_axis_tlast(ml0), .m_axis_tuser(mu0), .m_status_len(sl0),
    .m_status_bad(sb0), .m_status_trunc(st0), .m_status_valid(sv0), .m_status_ready(st_ready));

  axis_frame_reader #(.MAX_LEN(3)) u1 (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(v1), .s_axis_tready(r1),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .m_axis_tdata(md1), .m_axis_tvalid(mv1),
    .m_axis_tready(m_tready), .m_axis_tlast(ml1), .m_axis_tuser(mu1), .m_status_len(sl1),
    .m_status_bad(sb1), .m_status_trunc(st1), .m_status_valid(sv1), .m_status_ready(st_ready));

  axis_frame_reader #(.LEN_WIDTH(3), .MAX_LEN(0)) u2 (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(v2), .s_axis_tready(r2),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .m_axis_tdata(md2), .m_axis_tvalid(mv2),
    .m_axis_tready(m_tready), .m_axis_tlast(ml2), .m_axis_tuser(mu2), .m_status_len(sl2),
    .m_status_bad(sb2), .m_status_trunc(st2), .m_status_valid(sv2), .m_status_ready(st_ready));

  logic        c_rdy, c_mv, c_ml, c_mu, c_sb, c_st, c_sv;
  logic [7:0]  c_md;
  logic [15:0] c_sl;

  // Route the selected instance's outputs onto the observation bus.
  always_comb begin
    c_rdy = r0; c_mv = mv0; c_md = md0; c_ml = ml0; c_mu = mu0;
    c_sl = sl0; c_sb = sb0; c_st = st0; c_sv = sv0;
    case (sel)
      2'd1: begin
        c_rdy = r1; c_mv = mv1; c_md = md1; c_ml = ml1; c_mu = mu1;
        c_sl = sl1; c_sb = sb1; c_st = st1; c_sv = sv1;
      end
      2'd2: begin
        c_rdy = r2; c_mv = mv2; c_md = md2; c_ml = ml2; c_mu = mu2;
        c_sl = {13'd0, sl2}; c_sb = sb2; c_st = st2; c_sv = sv2;
      end
      default: ;
    endcase
  end

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t exp_q[$];
  logic  out_full = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int max_len_of(input int s);
    return (s == 1) ? 3 : 0;
  endfunction

  function automatic int len_sat_of(input int s);
    return (s == 2) ? 7 : 65535;
  endfunction

  // Send one frame of n beats to instance s and check everything observable.
  // mode: 0 downstream always ready, 1 ready toggling 1010, 2 random ready.
  task automatic run_frame(input int s, input int n, input logic last_user,
                           input int mode, input int sdelay, input logic fixed);
    logic [7:0] dat [16];
    logic       usr [16];
    int  ml, lsat, fwd_n, exp_len, idx, acc, cyc, st_wait;
    logic trunc, exp_bad, last_acc, pending, done, hold, accept, fwd_now;
    beat_t b, got;

    sel  = 2'(s);
    ml   = max_len_of(s);
    lsat = len_sat_of(s);
    for (int i = 0; i < n; i++) begin
      dat[i] = fixed ? 8'(8'h11 + i) : 8'($urandom);
      usr[i] = (i == n - 1) ? last_user : 1'($urandom);
    end
    trunc   = (ml != 0) && (n > ml);
    fwd_n   = trunc ? ml : n;
    exp_len = (n > lsat) ? lsat : n;
    exp_bad = last_user || trunc;
    for (int i = 0; i < fwd_n; i++) begin
      b.d = dat[i];
      b.l = (i == fwd_n - 1);
      b.u = (trunc && i == fwd_n - 1) ? 1'b1 : usr[i];
      exp_q.push_back(b);
    end

    idx = 0; acc = 0; cyc = 0; st_wait = 0;
    last_acc = 1'b0; pending = 1'b0; done = 1'b0; hold = 1'b0;
    while (!(done && exp_q.size() == 0) && cyc < 500) begin
      if (idx < n) begin
        if (!hold) s_tvalid = fixed ? 1'b1 : ($urandom_range(3) != 0);
        s_tdata = dat[idx];
        s_tuser = usr[idx];
        s_tlast = (idx == n - 1);
      end else begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
      end
      case (mode)
        1:       m_tready = (cyc % 2 == 0);
        2:       m_tready = 1'($urandom);
        default: m_tready = 1'b1;
      endcase
      st_ready = pending && (st_wait >= sdelay);
      #1;

      if (pending)
        chk("s_tready_status", c_rdy, 0);
      else if (ml != 0 && acc >= ml && !last_acc)
        chk("s_tready_drop", c_rdy, 1);
      else
        chk("s_tready_pass", c_rdy, !out_full || m_tready);
      chk("m_tvalid", c_mv, out_full);
      if (out_full && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("beat_extra", 0, 1);
        end else begin
          b = exp_q.pop_front();
          got = {c_md, c_ml, c_mu};
          chk("beat", got, b);
        end
      end
      chk("st_valid", c_sv, pending);
      if (pending) begin
        chk("st_len", c_sl, exp_len);
        chk("st_bad", c_sb, exp_bad);
        chk("st_trunc", c_st, trunc);
      end

      accept  = s_tvalid && c_rdy;
      fwd_now = accept && !(ml != 0 && acc >= ml);
      out_full = fwd_now || (out_full && !m_tready);
      if (pending) begin
        st_wait++;
        if (st_ready) begin
          pending = 1'b0;
          done = 1'b1;
        end
      end
      if (accept) begin
        acc++;
        if (s_tlast) begin
          last_acc = 1'b1;
          pending = 1'b1;
        end
        idx++;
      end
      hold = s_tvalid && !accept;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("frame_done", done, 1);
    chk("beats_left", exp_q.size(), 0);
    exp_q.delete();
    s_tvalid = 1'b0;
    st_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 2'd0; s_tdata = 8'd0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tuser = 1'b0; m_tready = 1'b0; st_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_tvalid", c_mv, 0);
    chk("rst_m_tdata", c_md, 0);
    chk("rst_m_tlast", c_ml, 0);
    chk("rst_m_tuser", c_mu, 0);
    chk("rst_st_valid", c_sv, 0);
    chk("rst_st_len", c_sl, 0);
    chk("rst_st_bad_trunc", {c_sb, c_st}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, 4, 1'b0, 0, 0, 1'b1);   // plain 4-beat frame
    run_frame(1, 6, 1'b0, 0, 0, 1'b1);   // truncated after 3 beats
    run_frame(1, 3, 1'b1, 0, 0, 1'b1);   // exact fit, bad marker
    run_frame(0, 8, 1'b0, 1, 0, 1'b1);   // downstream ready 1010
    run_frame(0, 3, 1'b0, 0, 5, 1'b1);   // status consumer stalls 5 cycles

    // Asynchronous reset in the middle of a frame, output register full.
    sel = 2'd0; s_tvalid = 1'b1; s_tdata = 8'hA1; s_tlast = 1'b0; s_tuser = 1'b0;
    m_tready = 1'b0;
    @(negedge clk);
    s_tdata = 8'hA2; m_tready = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0; m_tready = 1'b0;
    #1;
    chk("pre_rst_m_tvalid", c_mv, 1);
    chk("pre_rst_m_tdata", c_md, 8'hA2);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_m_tvalid", c_mv, 0);
    chk("async_rst_st_valid", c_sv, 0);
    chk("async_rst_m_tdata", c_md, 0);
    @(negedge clk);
    rst = 1'b0;
    out_full = 1'b0;
    run_frame(0, 5, 1'b1, 0, 0, 1'b0);   // length restarts from 1

    run_frame(2, 10, 1'b1, 0, 0, 1'b0);  // 3-bit counter saturates at 7
    run_frame(1, 1, 1'b0, 0, 0, 1'b0);   // single-beat frame

    for (int k = 0; k < 24; k++) begin
      run_frame($urandom_range(2), $urandom_range(1, 12), 1'($urandom),
                $urandom_range(2), $urandom_range(3), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
